// File: rtl/writeback_queue.sv
// In-order write-back buffer ahead of the register file write port, with read-port forwarding.
// Push lands at the head no earlier than the next cycle; wb_ready drops when full, even if a pop is under way.
module writeback_queue #(
  parameter int dataWidth = 4,
  parameter int addWidth  = 5,
  parameter int depth     = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         wb_valid,
  output logic                         wb_ready,
  input  logic [addWidth-1:0]          wb_register,
  input  logic [dataWidth-1:0]         wb_data,
  input  logic                         drain_en,
  output logic                         reg_write,
  output logic [addWidth-1:0]          write_register,
  output logic [dataWidth-1:0]         write_data,
  input  logic [addWidth-1:0]          read_register1,
  input  logic [addWidth-1:0]          read_register2,
  output logic                         fwd_hit1,
  output logic                         fwd_hit2,
  output logic [dataWidth-1:0]         fwd_data1,
  output logic [dataWidth-1:0]         fwd_data2,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int PW = $clog2(depth);
  localparam int CW = $clog2(depth+1);

  logic [PW-1:0]        r_head;
  logic [PW-1:0]        r_tail;
  logic [CW-1:0]        r_count;
  logic [depth-1:0]     r_vld;
  logic [addWidth-1:0]  r_reg [depth];
  logic [dataWidth-1:0] r_dat [depth];

  logic w_push;
  logic w_pop;
  logic [dataWidth:0] w_fwd1;
  logic [dataWidth:0] w_fwd2;

  assign empty          = (r_count == '0);
  assign full           = (r_count == CW'(depth));
  assign count          = r_count;
  assign wb_ready       = !full;
  assign reg_write      = drain_en && !empty;
  assign write_register = r_reg[r_head];
  assign write_data     = r_dat[r_head];

  assign w_push = wb_valid && wb_ready;
  assign w_pop  = reg_write;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_push) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Entry payload needs no reset; the valid bits gate every use of it.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_reg[r_tail] <= wb_register;
      r_dat[r_tail] <= wb_data;
    end
  end

  // Walk from head toward tail so a later (younger) match overrides an older one.
  function automatic logic [dataWidth:0] f_lookup(input logic [addWidth-1:0] rd);
    logic [dataWidth:0] res;
    logic [PW-1:0]      idx;
    res = '0;
    idx = '0;
    for (int i = 0; i < depth; i++) begin
      idx = r_head + PW'(i);
      if (r_vld[idx] && (r_reg[idx] == rd)) begin
        res = {1'b1, r_dat[idx]};
      end
    end
    return res;
  endfunction

  always_comb begin
    w_fwd1 = f_lookup(read_register1);
    w_fwd2 = f_lookup(read_register2);
  end

  assign fwd_hit1  = w_fwd1[dataWidth];
  assign fwd_data1 = w_fwd1[dataWidth-1:0];
  assign fwd_hit2  = w_fwd2[dataWidth];
  assign fwd_data2 = w_fwd2[dataWidth-1:0];

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: reset, fill, forwarding priority, push/pop overlap, full-with-pop, async reset.
module tb_writeback_queue;

  logic       clock;
  logic       reset;
  logic       wb_valid;
  logic       wb_ready;
  logic [4:0] wb_register;
  logic [3:0] wb_data;
  logic       drain_en;
  logic       reg_write;
  logic [4:0] write_register;
  logic [3:0] write_data;
  logic [4:0] read_register1;
  logic [4:0] read_register2;
  logic       fwd_hit1;
  logic       fwd_hit2;
  logic [3:0] fwd_data1;
  logic [3:0] fwd_data2;
  logic [2:0] count;
  logic       empty;
  logic       full;

  int n_cmp = 0;
  int n_err = 0;

  int e_reg[6] = '{7, 7, 10, 11, 12, 13};
  int e_dat[6] = '{10, 12, 0, 1, 2, 3};

  writeback_queue #(.dataWidth(4), .addWidth(5), .depth(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_register    (wb_register),
    .wb_data        (wb_data),
    .drain_en       (drain_en),
    .reg_write      (reg_write),
    .write_register (write_register),
    .write_data     (write_data),
    .read_register1 (read_register1),
    .read_register2 (read_register2),
    .fwd_hit1       (fwd_hit1),
    .fwd_hit2       (fwd_hit2),
    .fwd_data1      (fwd_data1),
    .fwd_data2      (fwd_data2),
    .count          (count),
    .empty          (empty),
    .full           (full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    wb_valid       = 1'b1;
    wb_register    = 5'd3;
    wb_data        = 4'h5;
    drain_en       = 1'b1;
    read_register1 = 5'd3;
    read_register2 = 5'd0;

    // Reset held across edges with a write presented
    cyc();
    cyc();
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ready", wb_ready, 1);
    chk("rst_regwrite", reg_write, 0);
    chk("rst_hit1", fwd_hit1, 0);
    chk("rst_fdata1", fwd_data1, 0);

    @(negedge clock);
    reset = 1'b0;
    cyc();
    wb_valid = 1'b0;
    #1;
    chk("first_regwrite", reg_write, 1);
    chk("first_wreg", write_register, 3);
    chk("first_wdata", write_data, 5);
    chk("first_count", count, 1);
    chk("first_hit1", fwd_hit1, 1);
    chk("first_fdata1", fwd_data1, 5);
    cyc();
    #1;
    chk("first_drained_count", count, 0);
    chk("first_drained_rw", reg_write, 0);

    // Fill
    drain_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wb_valid    = 1'b1;
      wb_register = 5'(i);
      wb_data     = 4'(i);
      cyc();
    end
    wb_register = 5'd5;
    wb_data     = 4'h5;
    #1;
    chk("fill_full", full, 1);
    chk("fill_ready", wb_ready, 0);
    chk("fill_count", count, 4);
    cyc();
    #1;
    chk("fill_fifth_ignored", count, 4);
    wb_valid = 1'b0;
    drain_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("drain_rw", reg_write, 1);
      chk("drain_wreg", write_register, i);
      chk("drain_wdata", write_data, i);
      cyc();
    end
    #1;
    chk("drain_empty", empty, 1);
    chk("drain_rw_off", reg_write, 0);

    // Forwarding priority
    drain_en    = 1'b0;
    wb_valid    = 1'b1;
    wb_register = 5'd7;
    wb_data     = 4'hA;
    cyc();
    wb_data = 4'hC;
    cyc();
    wb_valid       = 1'b0;
    read_register1 = 5'd7;
    read_register2 = 5'd9;
    #1;
    chk("fwd_count", count, 2);
    chk("fwd_hit1", fwd_hit1, 1);
    chk("fwd_data1_youngest", fwd_data1, 4'hC);
    chk("fwd_hit2_miss", fwd_hit2, 0);
    chk("fwd_data2_miss", fwd_data2, 0);

    // Simultaneous push and pop across pointer wrap
    for (int i = 0; i < 6; i++) begin
      wb_valid    = 1'b1;
      wb_register = 5'(10 + i);
      wb_data     = 4'(i);
      drain_en    = 1'b1;
      #1;
      chk("pp_count", count, 2);
      chk("pp_ready", wb_ready, 1);
      chk("pp_rw", reg_write, 1);
      chk("pp_wreg", write_register, e_reg[i]);
      chk("pp_wdata", write_data, e_dat[i]);
      chk("pp_hit1", fwd_hit1, (i < 2) ? 1 : 0);
      chk("pp_fdata1", fwd_data1, (i < 2) ? 4'hC : 4'h0);
      cyc();
    end
    wb_valid = 1'b0;
    drain_en = 1'b0;
    #1;
    chk("pp_after_count", count, 2);
    chk("pp_after_head", write_register, 14);

    // Full with a pop in the same cycle
    wb_valid    = 1'b1;
    wb_register = 5'd20;
    wb_data     = 4'h6;
    cyc();
    wb_register = 5'd21;
    wb_data     = 4'h7;
    cyc();
    wb_register = 5'd22;
    wb_data     = 4'h8;
    drain_en    = 1'b1;
    #1;
    chk("fp_full", full, 1);
    chk("fp_ready", wb_ready, 0);
    chk("fp_rw", reg_write, 1);
    chk("fp_wreg", write_register, 14);
    cyc();
    wb_valid       = 1'b0;
    drain_en       = 1'b0;
    read_register1 = 5'd15;
    read_register2 = 5'd22;
    #1;
    chk("fp_count", count, 3);
    chk("fp_ready_after", wb_ready, 1);
    chk("fp_no_push", fwd_hit2, 0);
    chk("fp_hit_r15", fwd_hit1, 1);
    chk("fp_head", write_register, 15);

    // Async reset between edges
    drain_en = 1'b1;
    #1;
    chk("ar_rw_before", reg_write, 1);
    reset = 1'b1;
    #1;
    chk("ar_count", count, 0);
    chk("ar_empty", empty, 1);
    chk("ar_full", full, 0);
    chk("ar_ready", wb_ready, 1);
    chk("ar_rw", reg_write, 0);
    chk("ar_hit1", fwd_hit1, 0);
    chk("ar_fdata1", fwd_data1, 0);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      chk("ar_no_drain", reg_write, 0);
      chk("ar_stays_empty", count, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
